reg_file_sb: RTL and testbench

//   16-entry x 16-bit general-purpose register file with busy-bit scoreboard.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/gpr_cell.sv | 26 ++
 rtl/reg_file_sb.sv | 86 ++++++++
 tb/tb_reg_file_sb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants for the register file and its cells.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 16;
  localparam int unsigned ADDR_W = 4;

  localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/gpr_cell.sv
// One general-purpose register: synchronous reset, write enable.
module gpr_cell
  import cpu_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (we) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_file_sb.sv
// 16x16 register file with per-register busy scoreboard and same-cycle
// write-to-read bypass; r0 reads as zero and is never busy.
module reg_file_sb
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             busy_q, busy_d;
  logic                        wr_ok, issue_ok;

  assign wr_ok    = wr_en && (wr_addr != REG_ZERO);
  assign issue_ok = issue_en && (issue_addr != REG_ZERO);

  assign regs[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_cell
    gpr_cell #(
      .W(DATA_W)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .we   (wr_ok && (wr_addr == ADDR_W'(i))),
      .d    (wr_data),
      .q    (regs[i])
    );
  end

  // Issue is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs_data = regs[rs_addr];
    rs_busy = busy_q[rs_addr];
    if (rs_addr == REG_ZERO) begin
      rs_data = '0;
      rs_busy = 1'b0;
    end else if (wr_en && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
      rs_busy = 1'b0;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
    rt_busy = busy_q[rt_addr];
    if (rt_addr == REG_ZERO) begin
      rt_data = '0;
      rt_busy = 1'b0;
    end else if (wr_en && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
      rt_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with an expected-value scoreboard queue.
module tb_reg_file_sb;

  logic        clk;
  logic        reset;
  logic [3:0]  rs_addr, rt_addr, issue_addr, wr_addr;
  logic [15:0] rs_data, rt_data, wr_data;
  logic        rs_busy, rt_busy, issue_en, wr_en;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  reg_file_sb dut (
    .clk       (clk),
    .reset     (reset),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %h want <queued value>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rs_addr = '0; rt_addr = '0; issue_addr = '0;
    wr_addr = '0; wr_data = '0; wr_en = 1'b0; issue_en = 1'b0;
    tick();
    reset = 1'b0;

    // 1: random writes/issues, then reset with write+issue also asserted
    for (int k = 0; k < 10; k++) begin
      wr_en      = 1'b1;
      wr_addr    = 4'($urandom_range(1, 15));
      wr_data    = 16'($urandom);
      issue_en   = 1'b1;
      issue_addr = 4'($urandom_range(1, 15));
      tick();
    end
    reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h5555;
    issue_en = 1'b1; issue_addr = 4'd11;
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 16; i++) begin
      rs_addr = 4'(i);
      rt_addr = 4'(i) ^ 4'hF;
      push_exp("reset_rs_data", 16'h0000);
      push_exp("reset_rt_data", 16'h0000);
      push_exp("reset_rs_busy", 16'h0000);
      push_exp("reset_rt_busy", 16'h0000);
      #1;
      chk(rs_data);
      chk(rt_data);
      chk({15'd0, rs_busy});
      chk({15'd0, rt_busy});
    end

    // 2: write r3, read it back the next cycle
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    tick();
    idle();
    rs_addr = 4'd3;
    push_exp("wr_r3_data", 16'hBEEF);
    push_exp("wr_r3_busy", 16'h0000);
    #1;
    chk(rs_data);
    chk({15'd0, rs_busy});

    // 3: same-cycle bypass on both ports
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    rs_addr = 4'd5; rt_addr = 4'd5;
    push_exp("bypass_rs", 16'h1234);
    push_exp("bypass_rt", 16'h1234);
    #1;
    chk(rs_data);
    chk(rt_data);
    tick();
    idle();
    push_exp("r5_after_wr", 16'h1234);
    #1;
    chk(rt_data);

    // 4: r0 ignores writes and issues, even during the writing cycle
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    issue_en = 1'b1; issue_addr = 4'd0; rs_addr = 4'd0;
    push_exp("r0_bypass_data", 16'h0000);
    #1;
    chk(rs_data);
    tick();
    idle();
    push_exp("r0_data", 16'h0000);
    push_exp("r0_busy", 16'h0000);
    #1;
    chk(rs_data);
    chk({15'd0, rs_busy});

    // 5: issue r7, then write-back clears busy with forwarded data
    issue_en = 1'b1; issue_addr = 4'd7;
    tick();
    idle();
    rt_addr = 4'd7;
    push_exp("r7_busy_set", 16'h0001);
    #1;
    chk({15'd0, rt_busy});
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA;
    push_exp("r7_wb_busy", 16'h0000);
    push_exp("r7_wb_data", 16'h00AA);
    #1;
    chk({15'd0, rt_busy});
    chk(rt_data);
    tick();
    idle();
    push_exp("r7_after_busy", 16'h0000);
    push_exp("r7_after_data", 16'h00AA);
    #1;
    chk({15'd0, rt_busy});
    chk(rt_data);

    // 6: simultaneous issue and write to r2 leaves it busy with new data
    issue_en = 1'b1; issue_addr = 4'd2;
    tick();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0042;
    tick();
    idle();
    rs_addr = 4'd2;
    push_exp("r2_data", 16'h0042);
    push_exp("r2_busy", 16'h0001);
    #1;
    chk(rs_data);
    chk({15'd0, rs_busy});

    // set and clear on different registers in one cycle
    issue_en = 1'b1; issue_addr = 4'd4;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0043;
    tick();
    idle();
    rs_addr = 4'd4; rt_addr = 4'd2;
    push_exp("r4_busy", 16'h0001);
    push_exp("r2_cleared", 16'h0000);
    push_exp("r2_data2", 16'h0043);
    #1;
    chk({15'd0, rs_busy});
    chk({15'd0, rt_busy});
    chk(rt_data);

    // reset while r9 busy
    issue_en = 1'b1; issue_addr = 4'd9;
    tick();
    idle();
    rt_addr = 4'd9;
    push_exp("r9_busy", 16'h0001);
    #1;
    chk({15'd0, rt_busy});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rs_addr = 4'd5;
    push_exp("r9_busy_reset", 16'h0000);
    push_exp("r5_reset", 16'h0000);
    #1;
    chk({15'd0, rt_busy});
    chk(rs_data);

    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: got %0d want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
